// File: rtl/gpio_in.sv
// rtl/gpio_in.sv - buffered GPIO input block with synchroniser, sticky change flags, mask and irq
module gpio_in #(
  parameter int size_addr = 2,
  parameter int size      = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 read,
  input  logic                 write,
  output logic                 ready_r,
  output logic                 ready_w,
  input  logic [size_addr-1:0] address,
  input  logic [7:0]           data_in,
  output logic [7:0]           data_out,
  input  logic [size*8-1:0]    port_in,
  output logic                 irq
);

  logic [size*8-1:0] r_s1;
  logic [size*8-1:0] r_s2;
  logic [size*8-1:0] r_prev;
  logic [size*8-1:0] r_flag;
  logic [size*8-1:0] r_mask;
  logic [7:0]        r_out_buf;
  logic              r_ready_r;
  logic              r_ready_w;
  logic              r_irq;
  logic [1:0]        r_warm;

  logic [size*8-1:0] w_change;
  logic [size*8-1:0] w_flag_clr;
  logic [size*8-1:0] w_mask_next;
  logic [7:0]        w_rd_data;

  // Edges are only trusted once the synchroniser and prev stage hold post-reset pin values
  assign w_change = (r_warm == 2'd3) ? (r_s2 ^ r_prev) : '0;

  // Read mux: DATA bytes, then FLAG bytes, then MASK bytes; holes read as zero
  always_comb begin
    w_rd_data = 8'h00;
    for (int i = 0; i < size; i++) begin
      if (int'(address) == i)          w_rd_data = r_s2[i*8 +: 8];
      if (int'(address) == size + i)   w_rd_data = r_flag[i*8 +: 8];
      if (int'(address) == 2*size + i) w_rd_data = r_mask[i*8 +: 8];
    end
  end

  // Write decode: W1C bits for FLAG bytes and replacement value for MASK bytes
  always_comb begin
    w_flag_clr  = '0;
    w_mask_next = r_mask;
    for (int i = 0; i < size; i++) begin
      if (write && (int'(address) == size + i))   w_flag_clr[i*8 +: 8]  = data_in;
      if (write && (int'(address) == 2*size + i)) w_mask_next[i*8 +: 8] = data_in;
    end
  end

  // Pin synchroniser, warm-up counter and edge history
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_prev <= '0;
      r_warm <= 2'd0;
    end else begin
      r_s1   <= port_in;
      r_s2   <= r_s1;
      r_prev <= r_s2;
      if (r_warm != 2'd3) r_warm <= r_warm + 2'd1;
    end
  end

  // Sticky flags (a new edge beats a same-cycle clear), mask register and irq
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flag <= '0;
      r_mask <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_flag <= (r_flag & ~w_flag_clr) | w_change;
      r_mask <= w_mask_next;
      r_irq  <= |(r_flag & r_mask);
    end
  end

  // Bus acknowledges and registered read data (captures pre-write register values)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ready_r <= 1'b0;
      r_ready_w <= 1'b0;
      r_out_buf <= 8'h00;
    end else begin
      r_ready_r <= read;
      r_ready_w <= write;
      if (read) r_out_buf <= w_rd_data;
    end
  end

  assign ready_r  = r_ready_r;
  assign ready_w  = r_ready_w;
  assign data_out = r_out_buf;
  assign irq      = r_irq;

endmodule

// File: tb/tb_gpio_in.sv
// tb/tb_gpio_in.sv - self-checking bench for gpio_in (size=1 and size=2 instances)
module tb_gpio_in;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        rd1, wr1;
  logic [1:0]  a1;
  logic [7:0]  di1;
  logic [7:0]  p1;
  logic        rr1, rw1, irq1;
  logic [7:0]  do1;

  logic        rd2, wr2;
  logic [2:0]  a2;
  logic [7:0]  di2;
  logic [15:0] p2;
  logic        rr2, rw2, irq2;
  logic [7:0]  do2;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state for the size=1 instance
  logic [7:0] m_pins, m_flag, m_mask;

  gpio_in #(.size_addr(2), .size(1)) u_dut (
    .clk(clk), .reset(reset), .read(rd1), .write(wr1),
    .ready_r(rr1), .ready_w(rw1), .address(a1), .data_in(di1),
    .data_out(do1), .port_in(p1), .irq(irq1)
  );

  gpio_in #(.size_addr(3), .size(2)) u_dut2 (
    .clk(clk), .reset(reset), .read(rd2), .write(wr2),
    .ready_r(rr2), .ready_w(rw2), .address(a2), .data_in(di2),
    .data_out(do2), .port_in(p2), .irq(irq2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_rd(input bit s, input logic [2:0] addr, output logic [7:0] d);
    if (!s) begin rd1 = 1'b1; a1 = addr[1:0]; end
    else    begin rd2 = 1'b1; a2 = addr;      end
    tick();
    if (!s) begin chk("rd_ack", {15'd0, rr1}, 16'd1); d = do1; rd1 = 1'b0; end
    else    begin chk("rd2_ack", {15'd0, rr2}, 16'd1); d = do2; rd2 = 1'b0; end
  endtask

  task automatic bus_wr(input bit s, input logic [2:0] addr, input logic [7:0] d);
    if (!s) begin wr1 = 1'b1; a1 = addr[1:0]; di1 = d; end
    else    begin wr2 = 1'b1; a2 = addr;      di2 = d; end
    tick();
    if (!s) begin chk("wr_ack", {15'd0, rw1}, 16'd1); wr1 = 1'b0; end
    else    begin chk("wr2_ack", {15'd0, rw2}, 16'd1); wr2 = 1'b0; end
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] v;
    bit         got;
    int         act;

    reset = 1'b0;
    rd1 = 0; wr1 = 0; a1 = 0; di1 = 0; p1 = 8'hA5;
    rd2 = 0; wr2 = 0; a2 = 0; di2 = 0; p2 = 16'h3C5A;
    m_flag = 8'h00; m_mask = 8'h00; m_pins = 8'hA5;

    // reset state
    repeat (3) tick();
    chk("rst_ready_r", {15'd0, rr1}, 16'd0);
    chk("rst_ready_w", {15'd0, rw1}, 16'd0);
    chk("rst_data_out", {8'd0, do1}, 16'd0);
    chk("rst_irq", {15'd0, irq1}, 16'd0);

    // release; read DATA at cycle 4, pins high at release never flag
    reset = 1'b1;
    repeat (3) tick();
    bus_rd(0, 3'd0, d);
    chk("warm_data", {8'd0, d}, 16'h00A5);
    tick();
    chk("ready_r_one_cycle", {15'd0, rr1}, 16'd0);
    bus_rd(0, 3'd1, d);
    chk("warm_no_flags", {8'd0, d}, 16'h0000);
    chk("warm_irq", {15'd0, irq1}, 16'd0);

    // edge capture: settle pins to 00, clear, then 00 -> 81
    p1 = 8'h00; m_flag |= m_pins ^ 8'h00; m_pins = 8'h00;
    repeat (4) tick();
    bus_wr(0, 3'd1, 8'hFF); m_flag = 8'h00;
    p1 = 8'h81; m_flag |= m_pins ^ 8'h81; m_pins = 8'h81;
    repeat (4) tick();
    bus_rd(0, 3'd1, d);
    chk("flag_rise", {8'd0, d}, 16'h0081);
    bus_wr(0, 3'd1, 8'h01); m_flag &= ~8'h01;
    bus_rd(0, 3'd1, d);
    chk("flag_w1c", {8'd0, d}, 16'h0080);
    p1 = 8'h00; m_flag |= m_pins ^ 8'h00; m_pins = 8'h00;
    repeat (4) tick();
    bus_rd(0, 3'd1, d);
    chk("flag_fall", {8'd0, d}, {8'd0, m_flag});
    bus_wr(0, 3'd1, 8'hFF); m_flag = 8'h00;

    // interrupt: only masked bit 1 raises irq
    bus_wr(0, 3'd2, 8'h02); m_mask = 8'h02;
    p1 = 8'h01; m_flag |= m_pins ^ 8'h01; m_pins = 8'h01;
    repeat (5) tick();
    chk("irq_unmasked_bit", {15'd0, irq1}, 16'd0);
    p1 = 8'h03; m_flag |= m_pins ^ 8'h03; m_pins = 8'h03;
    got = 1'b0;
    for (int k = 0; k < 4 && !got; k++) begin
      tick();
      if (irq1) got = 1'b1;
    end
    chk("irq_set_within_4", {15'd0, got}, 16'd1);
    bus_wr(0, 3'd1, 8'h02); m_flag &= ~8'h02;
    tick();
    chk("irq_clear", {15'd0, irq1}, 16'd0);
    bus_wr(0, 3'd1, 8'hFF); m_flag = 8'h00;

    // collision: W1C in the cycle s2 bit 3 changes -> set wins
    p1 = 8'h0B; m_pins = 8'h0B;
    tick();
    tick();
    wr1 = 1'b1; a1 = 2'd1; di1 = 8'hFF;
    tick();
    chk("collision_ack", {15'd0, rw1}, 16'd1);
    wr1 = 1'b0;
    m_flag = 8'h08;
    bus_rd(0, 3'd1, d);
    chk("collision_flag", {8'd0, d}, 16'h0008);

    // simultaneous read and write of MASK returns the pre-write value
    rd1 = 1'b1; wr1 = 1'b1; a1 = 2'd2; di1 = 8'h5C;
    tick();
    chk("rw_same_cycle", {8'd0, do1}, {8'd0, m_mask});
    rd1 = 1'b0; wr1 = 1'b0; m_mask = 8'h5C;
    bus_rd(0, 3'd2, d);
    chk("mask_after_rw", {8'd0, d}, 16'h005C);

    // randomized phase against the model
    for (int it = 0; it < 60; it++) begin
      act = $urandom_range(0, 4);
      case (act)
        0: begin
          v = 8'($urandom);
          p1 = v; m_flag |= m_pins ^ v; m_pins = v;
          repeat (4) tick();
        end
        1: begin
          v = 8'($urandom);
          bus_wr(0, 3'd1, v); m_flag &= ~v;
        end
        2: begin
          v = 8'($urandom);
          bus_wr(0, 3'd2, v); m_mask = v;
        end
        3: begin
          bus_rd(0, 3'd0, d); chk("rnd_data", {8'd0, d}, {8'd0, m_pins});
          bus_rd(0, 3'd1, d); chk("rnd_flag", {8'd0, d}, {8'd0, m_flag});
          bus_rd(0, 3'd2, d); chk("rnd_mask", {8'd0, d}, {8'd0, m_mask});
          bus_rd(0, 3'd3, d); chk("rnd_hole", {8'd0, d}, 16'h0000);
        end
        default: begin
          tick();
          chk("rnd_irq", {15'd0, irq1}, {15'd0, |(m_flag & m_mask)});
        end
      endcase
    end

    // size=2 instance
    bus_rd(1, 3'd0, d); chk("s2_data0", {8'd0, d}, 16'h005A);
    bus_rd(1, 3'd1, d); chk("s2_data1", {8'd0, d}, 16'h003C);
    bus_rd(1, 3'd2, d); chk("s2_flag0", {8'd0, d}, 16'h0000);
    bus_wr(1, 3'd5, 8'h77);
    bus_rd(1, 3'd5, d); chk("s2_mask1", {8'd0, d}, 16'h0077);
    bus_rd(1, 3'd4, d); chk("s2_mask0", {8'd0, d}, 16'h0000);
    bus_rd(1, 3'd6, d); chk("s2_hole6", {8'd0, d}, 16'h0000);
    bus_wr(1, 3'd7, 8'hEE);
    bus_rd(1, 3'd7, d); chk("s2_hole7", {8'd0, d}, 16'h0000);
    bus_rd(1, 3'd5, d); chk("s2_mask1_kept", {8'd0, d}, 16'h0077);

    // async reset in the middle of a read
    bus_wr(0, 3'd2, 8'hFF); m_mask = 8'hFF;
    v = m_pins ^ 8'h10;
    p1 = v; m_flag |= m_pins ^ v; m_pins = v;
    repeat (5) tick();
    chk("pre_rst_irq", {15'd0, irq1}, 16'd1);
    rd1 = 1'b1; a1 = 2'd2;
    tick();
    chk("pre_rst_data", {8'd0, do1}, 16'h00FF);
    #2 reset = 1'b0;
    #1;
    chk("arst_ready_r", {15'd0, rr1}, 16'd0);
    chk("arst_data_out", {8'd0, do1}, 16'd0);
    chk("arst_irq", {15'd0, irq1}, 16'd0);
    rd1 = 1'b0;
    tick();
    chk("arst_no_ack", {15'd0, rr1}, 16'd0);
    reset = 1'b1; m_flag = 8'h00; m_mask = 8'h00;
    repeat (4) tick();
    bus_rd(0, 3'd2, d); chk("arst_mask", {8'd0, d}, 16'h0000);
    bus_rd(0, 3'd1, d); chk("arst_flag", {8'd0, d}, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_in.md
Name: gpio_in

Overview:
Buffered GPIO input block. It is the read-side counterpart of the team's buffered GPIO output block and uses the same byte-wide read/write bus handshake. Each of `size` external input bytes passes through a two-flop synchroniser. The block also keeps sticky per-bit change flags, a per-bit interrupt mask and a registered interrupt line, so the CPU can poll inputs or take an interrupt on them.

Parameters:
size_addr  2  address width in bits; 3*size <= 2**size_addr is required
size       1  number of 8-bit input ports

Ports:
clk        input   1            system clock; all state is on the rising edge
reset      input   1            asynchronous reset, active-low (0 = reset)
read       input   1            bus read strobe, one cycle per access
write      input   1            bus write strobe, one cycle per access
ready_r    output  1            read acknowledge
ready_w    output  1            write acknowledge
address    input   size_addr    byte address
data_in    input   8            write data
data_out   output  8            registered read data
port_in    input   size*8       asynchronous external pins; byte i is port_in[i*8+7 -: 8]
irq        output  1            registered interrupt request

Behaviour:
- Reset: clk is the only clock. Reset is asynchronous and active-low on reset. While reset = 0, every register clears to 0: both synchroniser stages, prev, flags, mask, out_buf (data_out), ready_r, ready_w, irq and the warm-up counter. Reset asserted mid-access kills the access; no ack is issued.
- Synchroniser: s1 <= port_in; s2 <= s1; prev <= s2, every cycle. A pin change reaches s2 two clock edges later.
- Warm-up: 2-bit counter, incremented each cycle after reset release, saturating at 3. Change detection is enabled only when the counter is 3. Pins that are already high at reset release therefore never set flags.
- Change flags: when enabled, flag[n] is set if s2[n] != prev[n] (both edges). Flags are sticky until cleared.
- Address map, byte i in 0..size-1:
  - size*0+i: DATA, read-only; returns s2 byte i; writes are ignored.
  - size*1+i: FLAG; read returns the flags; writing clears each bit where data_in is 1 (write-1-to-clear).
  - size*2+i: MASK, read/write.
  - Any other address: reads return 8'h00, writes are ignored (still acked).
- Set/clear collision: a W1C write and a new change on the same bit in the same cycle leave the flag SET (set wins).
- Handshake: ready_r <= read and ready_w <= write every cycle, so both acks follow their strobe by exactly 1 cycle.
- Read data: on read, out_buf <= selected register value as it stood before the clock edge. out_buf holds otherwise. data_out = out_buf and is valid while ready_r = 1.
- Simultaneous read and write: both execute. The read returns the pre-write value.
- irq <= OR over all bits of (flag & mask). irq follows a flag or mask change by 1 cycle. It drops 1 cycle after the last enabled flag is cleared or masked.
- Back-to-back accesses on consecutive cycles are legal. No wait states.

Test Plan:
- Reset, size=1: hold reset=0 with port_in=8'hA5, then release. Expect all outputs 0. Expect flags to stay 0 (warm-up suppresses them). Read addr 0 at cycle 4 -> ready_r high at cycle 5, data_out=8'hA5.
- Edge capture: after warm-up, port_in 8'h00 -> 8'h81. Read FLAG addr 1 -> 8'h81. Write 8'h01 to addr 1, read again -> 8'h80. Drop port_in to 8'h00, read -> 8'h81.
- Interrupt: MASK=8'h02; toggle bit 0 -> irq stays 0. Toggle bit 1 -> irq=1 within 4 cycles of the pin change. Write FLAG 8'h02 -> irq=0 one cycle after the write.
- Collision: write 8'hFF to FLAG in the same cycle bit 3 changes in s2 -> FLAG reads 8'h08.
- size=2, size_addr=3: port_in=16'h3C5A. Read addr 0 -> 8'h5A, addr 1 -> 8'h3C. Write/read MASK addr 5 = 8'h77. Read addr 6 -> 8'h00, write to addr 7 acked and ignored.
- Asynchronous reset during a read: assert reset between the read strobe and the next edge -> ready_r=0, data_out=0 immediately, irq=0, MASK reads 8'h00 after release.
